fmeter_ctrl: RTL

Measurement sequencer for the `fmeter` reciprocal frequency counter. Accepts a start request and gate length from the host/MCU register side, drives `fmeter`'s `clr` and `ss` through a fixed clear → gate → stop sequence, and captures `cntx`/`cnts`/`ovx`/`ovs` once `sta` confirms the synchronized gate has closed. Holds the result behind a valid/ready handshake, with optional continuous re-arm. Sits between the register interface and `fmeter`, clocked by the same standard clock `fs`.

---
 rtl/fmeter_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fmeter_ctrl.sv
// Clear -> gate -> stop sequencer for the fmeter reciprocal counter, with a valid/ready result.
// Define FMCTRL_TIMEOUT_EN to build the STOP-state timeout that ends a wait for m_sta to fall.
module fmeter_ctrl #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned GATE_W  = 24,
  parameter int unsigned TMO_CYC = 1048575
) (
  input  logic              fs,
  input  logic              clr_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              m_clr,
  output logic              m_ss,
  input  logic              m_sta,
  input  logic              m_ovx,
  input  logic              m_ovs,
  input  logic [CNT_W-1:0]  m_cntx,
  input  logic [CNT_W-1:0]  m_cnts,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_cntx,
  output logic [CNT_W-1:0]  res_cnts,
  output logic              res_ovx,
  output logic              res_ovs,
  output logic              res_nosig,
  output logic              res_tmo
);

  if (TMO_CYC == 0 || GATE_W < 2 || CNT_W == 0) begin : g_param_chk
    $error("fmeter_ctrl: TMO_CYC must be nonzero, GATE_W >= 2, CNT_W >= 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StGate,
    StStop,
    StLatch,
    StDone
  } state_e;

  state_e             state;
  logic [GATE_W-1:0]  glen;
  logic [GATE_W-1:0]  gcnt;
  logic               clr_cnt;
  logic               sta_seen;
  logic [GATE_W-1:0]  glen_eff;

  // A gate shorter than two cycles cannot be synchronized by fmeter.
  assign glen_eff = (gate_len < GATE_W'(2)) ? GATE_W'(2) : gate_len;

`ifdef FMCTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
`else
  assign res_tmo = 1'b0;
`endif

  always_ff @(posedge fs or negedge clr_n) begin
    if (!clr_n) begin
      state     <= StIdle;
      glen      <= '0;
      gcnt      <= '0;
      clr_cnt   <= 1'b0;
      sta_seen  <= 1'b0;
      busy      <= 1'b0;
      m_clr     <= 1'b0;
      m_ss      <= 1'b0;
      res_valid <= 1'b0;
      res_cntx  <= '0;
      res_cnts  <= '0;
      res_ovx   <= 1'b0;
      res_ovs   <= 1'b0;
      res_nosig <= 1'b0;
`ifdef FMCTRL_TIMEOUT_EN
      tmo_cnt   <= '0;
      tmo_hit   <= 1'b0;
      res_tmo   <= 1'b0;
`endif
    end else if (abort) begin
      // Result registers deliberately keep their last contents.
      state     <= StIdle;
      busy      <= 1'b0;
      m_clr     <= 1'b0;
      m_ss      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            glen     <= glen_eff;
            state    <= StClr;
            busy     <= 1'b1;
            m_clr    <= 1'b1;
            clr_cnt  <= 1'b0;
            sta_seen <= 1'b0;
          end
        end
        StClr: begin
          if (clr_cnt) begin
            state <= StGate;
            m_clr <= 1'b0;
            m_ss  <= 1'b1;
            gcnt  <= GATE_W'(1);
          end else begin
            clr_cnt <= 1'b1;
          end
        end
        StGate: begin
          if (m_sta) begin
            sta_seen <= 1'b1;
          end
          if (gcnt == glen) begin
            state <= StStop;
            m_ss  <= 1'b0;
`ifdef FMCTRL_TIMEOUT_EN
            tmo_cnt <= '0;
            tmo_hit <= 1'b0;
`endif
          end else begin
            gcnt <= gcnt + GATE_W'(1);
          end
        end
        StStop: begin
          if (!sta_seen || !m_sta) begin
            state <= StLatch;
          end
`ifdef FMCTRL_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            tmo_hit <= 1'b1;
            state   <= StLatch;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        StLatch: begin
          // No sta edge during the gate means no fx: report zeros, not stale counts.
          res_cntx  <= sta_seen ? m_cntx : '0;
          res_cnts  <= sta_seen ? m_cnts : '0;
          res_ovx   <= sta_seen & m_ovx;
          res_ovs   <= sta_seen & m_ovs;
          res_nosig <= ~sta_seen;
`ifdef FMCTRL_TIMEOUT_EN
          res_tmo   <= tmo_hit;
`endif
          res_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (cont) begin
              state    <= StClr;
              m_clr    <= 1'b1;
              clr_cnt  <= 1'b0;
              sta_seen <= 1'b0;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          m_clr <= 1'b0;
          m_ss  <= 1'b0;
        end
      endcase
    end
  end

endmodule
